bwn_xnor_popcount: RTL and testbench

//  Downstream consumer of the BWN input shift register.
//  - Once the shift register holds a full BL-bit binarized activation vector, this block latches it with a binarized weight vector.
//  - It forms XNOR(act, weight) and accumulates the popcount CW bits per cycle.
//  - It thresholds the count into one binarized neuron output.
//  - The result is held under a valid/ack handshake until the next layer stage takes it.

---
 rtl/bwn_xnor_popcount_if.sv | 32 +++
 rtl/bwn_xnor_popcount.sv | 149 ++++++++++++++
 tb/tb_bwn_xnor_popcount.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bwn_xnor_popcount_if.sv
// Handshake/bus bundle for bwn_xnor_popcount.
// When BWN_SIGNED_SUM_EN is defined, iTHRESH/oSUM widen by one bit for the signed +/-1 dot product.
interface bwn_xnor_popcount_if #(
   parameter int BL = 154
);
   localparam int AW = $clog2(BL + 1);
`ifdef BWN_SIGNED_SUM_EN
   localparam int SW = AW + 1;
`else
   localparam int SW = AW;
`endif

   logic          iLOAD;
   logic [BL-1:0] iDATA;
   logic [BL-1:0] iWEIGHT;
   logic [SW-1:0] iTHRESH;
   logic          iACK;
   logic          oREADY;
   logic          oVALID;
   logic [SW-1:0] oSUM;
   logic          oBIT;

   modport master (
      output iLOAD, iDATA, iWEIGHT, iTHRESH, iACK,
      input  oREADY, oVALID, oSUM, oBIT
   );

   modport slave (
      input  iLOAD, iDATA, iWEIGHT, iTHRESH, iACK,
      output oREADY, oVALID, oSUM, oBIT
   );
endinterface

// File: rtl/bwn_xnor_popcount.sv
// XNOR-popcount binarized neuron: latches act/weight, popcounts CW bits per cycle, thresholds, holds result under valid/ack.
// Optional macro BWN_SIGNED_SUM_EN: oSUM = 2*popcount - BL (signed) with signed threshold compare.
module bwn_xnor_popcount #(
   parameter int BL = 154,
   parameter int CW = 16
) (
   input  logic               iCLK,
   input  logic               iRST_n,
   input  logic               iCLR,
   bwn_xnor_popcount_if.slave bus
);
   localparam int NCH = (BL + CW - 1) / CW;
   localparam int AW  = $clog2(BL + 1);
`ifdef BWN_SIGNED_SUM_EN
   localparam int SW  = AW + 1;
`else
   localparam int SW  = AW;
`endif
   localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int PW  = $clog2(CW + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [BL-1:0]          r_x;
   logic [SW-1:0]          r_thr;
   logic [AW-1:0]          r_acc;
   logic [IW-1:0]          r_idx;
   logic [SW-1:0]          r_sum;
   logic                   r_bit;
   logic                   r_valid;

   logic                   w_ready;
   logic                   w_accept;
   logic                   w_step;
   logic                   w_last;
   logic                   w_done_ack;
   logic [NCH-1:0][CW-1:0] w_xpad;
   logic [CW-1:0]          w_chunk;
   logic [PW-1:0]          w_pop;
   logic [AW-1:0]          w_final;
   logic [SW-1:0]          w_res;
   logic                   w_ge;

   // Zero-padding above BL masks the tail of the last chunk.
   assign w_xpad = (NCH * CW)'(r_x);

   if (NCH == 1) begin : g_one_chunk
      assign w_chunk = w_xpad[0];
   end else begin : g_multi_chunk
      assign w_chunk = w_xpad[r_idx];
   end

   always_comb begin
      w_pop = '0;
      for (int unsigned i = 0; i < CW; i++) begin
         w_pop = w_pop + PW'(w_chunk[i]);
      end
   end

   assign w_final = r_acc + AW'(w_pop);

`ifdef BWN_SIGNED_SUM_EN
   assign w_res = {w_final, 1'b0} - SW'(BL);
   assign w_ge  = $signed(w_res) >= $signed(r_thr);
`else
   assign w_res = w_final;
   assign w_ge  = w_res >= r_thr;
`endif

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (iCLR) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE: begin
               if (w_accept) begin
                  w_state_nxt = S_RUN;
               end else if (bus.iACK) begin
                  w_state_nxt = S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_ready    = (r_state == S_IDLE) | ((r_state == S_DONE) & bus.iACK);
      w_accept   = bus.iLOAD & w_ready;
      w_step     = (r_state == S_RUN);
      w_last     = w_step & (r_idx == IW'(NCH - 1));
      w_done_ack = (r_state == S_DONE) & bus.iACK;
   end

   // Result registers survive iCLR; only the in-flight accumulation is discarded.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         r_x     <= '0;
         r_thr   <= '0;
         r_acc   <= '0;
         r_idx   <= '0;
         r_sum   <= '0;
         r_bit   <= 1'b0;
         r_valid <= 1'b0;
      end else if (iCLR) begin
         r_acc   <= '0;
         r_idx   <= '0;
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_x     <= ~(bus.iDATA ^ bus.iWEIGHT);
         r_thr   <= bus.iTHRESH;
         r_acc   <= '0;
         r_idx   <= '0;
         r_valid <= 1'b0;
      end else if (w_step) begin
         r_acc <= w_final;
         r_idx <= r_idx + IW'(1);
         if (w_last) begin
            r_sum   <= w_res;
            r_bit   <= w_ge;
            r_valid <= 1'b1;
         end
      end else if (w_done_ack) begin
         r_valid <= 1'b0;
      end
   end

   assign bus.oREADY = w_ready;
   assign bus.oVALID = r_valid;
   assign bus.oSUM   = r_sum;
   assign bus.oBIT   = r_bit;
endmodule

// File: tb/tb_bwn_xnor_popcount.sv
// Randomized self-checking bench for bwn_xnor_popcount against a $countones-based reference model.
module tb_bwn_xnor_popcount;
   localparam int BL  = 154;
   localparam int CW  = 16;
   localparam int NCH = (BL + CW - 1) / CW;
   localparam int AW  = $clog2(BL + 1);
`ifdef BWN_SIGNED_SUM_EN
   localparam int SW  = AW + 1;
`else
   localparam int SW  = AW;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic clr   = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;
   logic [SW-1:0] last_sum = '0;
   logic          last_bit = 1'b0;

   always #5 clk = ~clk;

   bwn_xnor_popcount_if #(.BL(BL)) bus ();

   bwn_xnor_popcount #(.BL(BL), .CW(CW)) dut (
      .iCLK  (clk),
      .iRST_n(rst_n),
      .iCLR  (clr),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_pc(input logic [BL-1:0] d, input logic [BL-1:0] w);
      return $countones(~(d ^ w));
   endfunction

   function automatic logic [SW-1:0] model_sum(input int pc);
`ifdef BWN_SIGNED_SUM_EN
      return SW'(2 * pc - BL);
`else
      return SW'(pc);
`endif
   endfunction

   function automatic logic model_bit(input int pc, input logic [SW-1:0] thr);
`ifdef BWN_SIGNED_SUM_EN
      int t;
      t = int'($signed(thr));
      return (2 * pc - BL) >= t;
`else
      return pc >= int'(thr);
`endif
   endfunction

   // Starts just after a negedge with the DUT ready; returns one negedge after the accept edge.
   task automatic issue(input string tag, input logic [BL-1:0] d, input logic [BL-1:0] w,
                        input logic [SW-1:0] thr);
      bus.iLOAD   = 1'b1;
      bus.iDATA   = d;
      bus.iWEIGHT = w;
      bus.iTHRESH = thr;
      #1;
      chk({tag, "_ready"}, 32'(bus.oREADY), 32'd1);
      @(negedge clk);
      bus.iLOAD = 1'b0;
      bus.iACK  = 1'b0;
   endtask

   task automatic wait_check(input string tag, input logic [BL-1:0] d, input logic [BL-1:0] w,
                             input logic [SW-1:0] thr);
      int k;
      int pc;
      k = 0;
      while (bus.oVALID !== 1'b1 && k < 4 * NCH + 10) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_lat"}, 32'(k), 32'(NCH));
      pc = model_pc(d, w);
      last_sum = model_sum(pc);
      last_bit = model_bit(pc, thr);
      chk({tag, "_sum"}, 32'(bus.oSUM), 32'(last_sum));
      chk({tag, "_bit"}, 32'(bus.oBIT), 32'(last_bit));
   endtask

   task automatic ack_idle(input string tag);
      bus.iACK = 1'b1;
      @(negedge clk);
      bus.iACK = 1'b0;
      #1;
      chk({tag, "_ackvalid"}, 32'(bus.oVALID), 32'd0);
      chk({tag, "_ackready"}, 32'(bus.oREADY), 32'd1);
   endtask

   function automatic logic [BL-1:0] rand_vec();
      logic [BL-1:0] v;
      for (int i = 0; i < BL; i++) v[i] = 1'($urandom_range(0, 1));
      return v;
   endfunction

   function automatic logic [SW-1:0] rand_thr(input int pc);
      int sel;
      int s;
`ifdef BWN_SIGNED_SUM_EN
      s = 2 * pc - BL;
      sel = $urandom_range(0, 2);
      if (sel == 0) return SW'(s);
      if (sel == 1) return SW'(s + 1);
      return SW'(int'($urandom_range(0, 2 * BL)) - BL);
`else
      s = pc;
      sel = $urandom_range(0, 2);
      if (sel == 0) return SW'(s);
      if (sel == 1) return SW'(s + 1);
      return SW'($urandom_range(0, BL));
`endif
   endfunction

   initial begin
      logic [BL-1:0] d;
      logic [BL-1:0] w;
      logic [SW-1:0] thr;
      logic [SW-1:0] held_sum;
      logic          held_bit;
      bit            b2b;
      int            p;

      bus.iLOAD   = 1'b0;
      bus.iDATA   = '0;
      bus.iWEIGHT = '0;
      bus.iTHRESH = '0;
      bus.iACK    = 1'b0;

      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(bus.oVALID), 32'd0);
      chk("rst_sum",   32'(bus.oSUM),   32'd0);
      chk("rst_bit",   32'(bus.oBIT),   32'd0);
      chk("rst_ready", 32'(bus.oREADY), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // all-zero act and weight: every bit matches
      d = '0; w = '0;
`ifdef BWN_SIGNED_SUM_EN
      thr = SW'(77);
`else
      thr = SW'(77);
`endif
      issue("t1", d, w, thr);
      wait_check("t1", d, w, thr);
      chk("t1_const", 32'(bus.oSUM), 32'(model_sum(BL)));
      ack_idle("t1");

      // complementary vectors: no bit matches
      w = rand_vec(); d = ~w;
`ifdef BWN_SIGNED_SUM_EN
      thr = SW'(-BL);
`else
      thr = SW'(1);
`endif
      issue("t2", d, w, thr);
      wait_check("t2", d, w, thr);
      ack_idle("t2");

      // 144 matches, threshold just above; then stall without ack
      d = '1; w = '1; w[9:0] = '0; thr = SW'(145);
      issue("t3", d, w, thr);
      wait_check("t3", d, w, thr);
      held_sum = last_sum;
      held_bit = last_bit;
      for (int i = 0; i < 5; i++) begin
         bus.iLOAD = 1'b1;
         bus.iDATA = rand_vec();
         bus.iWEIGHT = rand_vec();
         #1;
         chk("t3_stall_ready", 32'(bus.oREADY), 32'd0);
         @(negedge clk);
         chk("t3_stall_valid", 32'(bus.oVALID), 32'd1);
         chk("t3_stall_sum",   32'(bus.oSUM),   32'(held_sum));
         chk("t3_stall_bit",   32'(bus.oBIT),   32'(held_bit));
      end
      bus.iLOAD = 1'b0;
      ack_idle("t3");
      repeat (NCH + 2) begin
         @(negedge clk);
         chk("t3_idle_valid", 32'(bus.oVALID), 32'd0);
      end

      // back-to-back: ack and load in the same DONE cycle
      d = rand_vec(); w = rand_vec(); thr = rand_thr(model_pc(d, w));
      issue("t4a", d, w, thr);
      wait_check("t4a", d, w, thr);
      d = rand_vec(); w = rand_vec(); thr = rand_thr(model_pc(d, w));
      bus.iACK = 1'b1;
      issue("t4b", d, w, thr);
      wait_check("t4b", d, w, thr);
      ack_idle("t4b");

      // abort mid-RUN, result registers must keep the previous value
      held_sum = last_sum;
      held_bit = last_bit;
      d = rand_vec(); w = rand_vec();
      issue("t5a", d, w, SW'(0));
      repeat (3) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("t5_clr_ready", 32'(bus.oREADY), 32'd1);
      chk("t5_clr_sum",   32'(bus.oSUM),   32'(held_sum));
      chk("t5_clr_bit",   32'(bus.oBIT),   32'(held_bit));
      repeat (NCH + 2) begin
         @(negedge clk);
         chk("t5_clr_valid", 32'(bus.oVALID), 32'd0);
      end
      d = '0; w = '0; thr = SW'(77);
      issue("t5b", d, w, thr);
      wait_check("t5b", d, w, thr);
      ack_idle("t5b");

      // async reset mid-RUN and mid-DONE
      d = rand_vec(); w = rand_vec(); thr = rand_thr(model_pc(d, w));
      issue("t6a", d, w, thr);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t6a_valid", 32'(bus.oVALID), 32'd0);
      chk("t6a_sum",   32'(bus.oSUM),   32'd0);
      chk("t6a_bit",   32'(bus.oBIT),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("t6a_ready", 32'(bus.oREADY), 32'd1);
      d = '0; w = '0; thr = SW'(0);
      issue("t6b", d, w, thr);
      wait_check("t6b", d, w, thr);
      #2 rst_n = 1'b0;
      #1;
      chk("t6b_valid", 32'(bus.oVALID), 32'd0);
      chk("t6b_sum",   32'(bus.oSUM),   32'd0);
      chk("t6b_bit",   32'(bus.oBIT),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("t6b_ready", 32'(bus.oREADY), 32'd1);
      @(negedge clk);

      // randomized vectors with varied match density, mixed idle/back-to-back
      b2b = 1'b0;
      for (int n = 0; n < 30; n++) begin
         w = rand_vec();
         p = $urandom_range(0, 100);
         for (int i = 0; i < BL; i++) d[i] = ($urandom_range(0, 99) < p) ? ~w[i] : w[i];
         thr = rand_thr(model_pc(d, w));
         if (b2b) bus.iACK = 1'b1;
         issue("rnd", d, w, thr);
         wait_check("rnd", d, w, thr);
         b2b = 1'($urandom_range(0, 1));
         if (!b2b) begin
            ack_idle("rnd");
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end
      if (b2b) ack_idle("rnd_end");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
